// File: rtl/gameboy_p1_reg.sv
// P1/JOYP register at 0xFF00: drives the P15/P14 selects, synchronises P13..P10,
// and raises the joypad IRQ on falling edges outside the post-select settle window.
module gameboy_p1_reg #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       P15,
  output logic       P14,
  input  logic       P13,
  input  logic       P12,
  input  logic       P11,
  input  logic       P10,
  output logic       irq_joypad,
  output logic       wake
);

  localparam int unsigned CW = 8;

  logic [1:0]    sel;
  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    line_s;
  logic [3:0]    prev;
  logic [3:0]    fall;
  logic [CW-1:0] settle;
  logic          wr_en;
  logic          rd_en;
  logic          sel_change;
  logic          unused_wdata;

  assign wr_en        = cs & wr;
  assign rd_en        = cs & rd;
  assign sel_change   = wr_en & (wdata[5:4] != sel);
  assign line_s       = sync_q[SYNC_STAGES-1];
  assign fall         = prev & ~line_s;
  assign P15          = sel[1];
  assign P14          = sel[0];
  assign wake         = ~&line_s;
  assign unused_wdata = ^{wdata[7:6], wdata[3:0]};

  // Select register
  always_ff @(posedge clk) begin
    if (reset) begin
      sel <= 2'b00;
    end else if (wr_en) begin
      sel <= wdata[5:4];
    end
  end

  // Pin synchroniser and previous-sample register for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'hF;
      end
      prev <= 4'hF;
    end else begin
      sync_q[0] <= {P13, P12, P11, P10};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev <= line_s;
    end
  end

  // Settle window: reload on an actual select change, otherwise count down to 0
  always_ff @(posedge clk) begin
    if (reset) begin
      settle <= '0;
    end else if (sel_change) begin
      settle <= CW'(SETTLE_CYCLES);
    end else if (settle != '0) begin
      settle <= settle - CW'(1);
    end
  end

  // IRQ pulse and CPU read port; read data reflects the pre-write select
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_joypad <= 1'b0;
      rdata      <= 8'hFF;
      rvalid     <= 1'b0;
    end else begin
      irq_joypad <= (|fall) & (settle == '0);
      rvalid     <= rd_en;
      if (rd_en) begin
        rdata <= {2'b11, sel, line_s};
      end
    end
  end

endmodule

// File: tb/tb_gameboy_p1_reg.sv
// Directed bench for gameboy_p1_reg with a cycle-history reference model checked every cycle.
module tb_gameboy_p1_reg;

  localparam int SS = 2;
  localparam int ST = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs, wr, rd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid, P15, P14, irq_joypad, wake;
  logic [3:0] pins;

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;

  gameboy_p1_reg #(.SYNC_STAGES(SS), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wr(wr), .rd(rd), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .P15(P15), .P14(P14),
    .P13(pins[3]), .P12(pins[2]), .P11(pins[1]), .P10(pins[0]),
    .irq_joypad(irq_joypad), .wake(wake)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin history per edge; line_s is the pin value SS edges ago,
  // masking holds until ST full cycles after the edge of a select-changing write.
  logic [3:0] hist [0:5];
  logic [1:0] m_sel;
  logic [7:0] m_rdata;
  logic       m_rvalid, m_irq, m_wake;
  int         cyc = 0;
  int         last_w = -1000;
  bit         model_ok = 0;

  always @(posedge clk) begin
    logic [3:0] line, prv;
    if (reset) begin
      for (int i = 0; i < 6; i++) hist[i] = 4'hF;
      m_sel = 2'b00; m_rdata = 8'hFF; m_rvalid = 0; m_irq = 0; m_wake = 0;
      last_w = -1000;
    end else begin
      for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pins;
      line = hist[SS];
      prv  = hist[SS+1];
      m_irq = (|(prv & ~line)) && !(cyc < last_w + 1 + ST);
      m_rvalid = cs && rd;
      if (cs && rd) m_rdata = {2'b11, m_sel, line};
      if (cs && wr) begin
        if (wdata[5:4] != m_sel) last_w = cyc;
        m_sel = wdata[5:4];
      end
      m_wake = ~&hist[SS-1];
    end
    cyc++;
    model_ok = 1;
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (model_ok) begin
      check("rdata", rdata, m_rdata);
      check("rvalid", 8'(rvalid), 8'(m_rvalid));
      check("P15", 8'(P15), 8'(m_sel[1]));
      check("P14", 8'(P14), 8'(m_sel[0]));
      check("irq_joypad", 8'(irq_joypad), 8'(m_irq));
      check("wake", 8'(wake), 8'(m_wake));
      if (irq_joypad === 1'b1) irq_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] d);
    cs = 1; wr = 1; wdata = d;
    @(negedge clk);
    cs = 0; wr = 0; wdata = 8'h00;
  endtask

  task automatic do_read(input logic [7:0] exp, input string name);
    cs = 1; rd = 1;
    @(negedge clk);
    cs = 0; rd = 0;
    check({name, "_rvalid"}, 8'(rvalid), 8'h01);
    check(name, rdata, exp);
    @(negedge clk);
    check({name, "_rvalid_drop"}, 8'(rvalid), 8'h00);
    check({name, "_hold"}, rdata, exp);
  endtask

  initial begin
    int snap;
    reset = 1; cs = 0; wr = 0; rd = 0; wdata = 8'h00; pins = 4'hF;
    cycles(3);
    reset = 0;
    cycles(2);

    // Reset state and idle read
    check("rst_P15", 8'(P15), 8'h00);
    check("rst_P14", 8'(P14), 8'h00);
    check("rst_irq", 8'(irq_joypad), 8'h00);
    check("rst_wake", 8'(wake), 8'h00);
    do_read(8'hCF, "read_idle");

    // Directions selected, P10 falls after the window
    do_write(8'h20);
    cycles(ST + 2);
    pins = 4'hE;
    repeat (SS) begin
      @(negedge clk);
      check("p10_irq_early", 8'(irq_joypad), 8'h00);
    end
    @(negedge clk);
    check("p10_irq_pulse", 8'(irq_joypad), 8'h01);
    @(negedge clk);
    check("p10_irq_single", 8'(irq_joypad), 8'h00);
    do_read(8'hEE, "read_dir");
    check("p10_wake", 8'(wake), 8'h01);
    pins = 4'hF;
    cycles(10);

    // Select change exposes a low P11 inside the window: masked
    snap = irq_cnt;
    pins = 4'hD;
    do_write(8'h10);
    cycles(15);
    check("masked_cnt", 8'(irq_cnt - snap), 8'h00);
    pins = 4'hF;
    cycles(20);
    pins = 4'hD;
    cycles(10);
    check("p11_refall_cnt", 8'(irq_cnt - snap), 8'h01);
    pins = 4'hF;
    cycles(10);

    // Two lines fall together, then held low
    snap = irq_cnt;
    pins = 4'h6;
    cycles(10);
    check("dual_fall_cnt", 8'(irq_cnt - snap), 8'h01);
    cycles(50);
    check("held_low_cnt", 8'(irq_cnt - snap), 8'h01);
    pins = 4'hF;
    cycles(10);
    check("release_cnt", 8'(irq_cnt - snap), 8'h01);

    // Same-value writes do not reload the window
    do_write(8'h30);
    cycles(ST + 4);
    snap = irq_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) pins = 4'hB;
      cs = 1; wr = 1; wdata = 8'h30;
      @(negedge clk);
    end
    cs = 0; wr = 0; wdata = 8'h00;
    cycles(5);
    check("same_write_cnt", 8'(irq_cnt - snap), 8'h01);
    do_read(8'hFB, "read_both");
    pins = 4'hF;
    cycles(10);

    // Reset inside a settle window with P10 low, then re-detection
    pins = 4'hE;
    do_write(8'h20);
    cycles(1);
    reset = 1;
    @(negedge clk);
    check("mid_rst_P15", 8'(P15), 8'h00);
    check("mid_rst_P14", 8'(P14), 8'h00);
    check("mid_rst_irq", 8'(irq_joypad), 8'h00);
    check("mid_rst_rdata", rdata, 8'hFF);
    check("mid_rst_wake", 8'(wake), 8'h00);
    @(negedge clk);
    reset = 0;
    repeat (SS) begin
      @(negedge clk);
      check("post_rst_irq_early", 8'(irq_joypad), 8'h00);
    end
    @(negedge clk);
    check("post_rst_irq_pulse", 8'(irq_joypad), 8'h01);
    @(negedge clk);
    check("post_rst_irq_single", 8'(irq_joypad), 8'h00);
    pins = 4'hF;
    cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
